// File: rtl/ahb_lite_sram_ws.sv
// AHB-Lite memory slave wrapping an inferred 32-bit synchronous RAM.
// Features: a word depth that need not be a power of two, 0..3 read wait
// states, and read-after-write forwarding. Out-of-range accesses and
// HSIZE > 2 get a two-cycle ERROR response.
module ahb_lite_sram_ws #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DEPTH_WORDS = 4096,
  parameter int READ_WS     = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int IDXW = ADDR_WIDTH - 2;
  localparam int MEMW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] WS = 2'(READ_WS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      r_cnt;
  logic [31:0]     r_mem [0:DEPTH_WORDS-1];
  logic            r_wpend;
  logic [MEMW-1:0] r_waddr;
  logic [3:0]      r_wlanes;
  logic            r_rdpend;
  logic [31:0]     r_ramq;
  logic [31:0]     r_hold;

  logic [IDXW-1:0] w_idx;
  logic [MEMW-1:0] w_midx;
  logic            w_inrange;
  logic            w_canacc;
  logic            w_accept;
  logic            w_fault;
  logic            w_accrd;
  logic            w_accwr;
  logic            w_we;
  logic            w_fwd;
  logic            w_ready;
  logic [3:0]      w_lanes;
  logic [31:0]     w_rword;
  logic            w_unused;

  assign w_idx     = HADDR[ADDR_WIDTH-1:2];
  assign w_midx    = w_idx[MEMW-1:0];
  assign w_inrange = {{(32-IDXW){1'b0}}, w_idx} < 32'(DEPTH_WORDS);

  // Only IDLE and ERR2 drive HREADYOUT high, so only they can take a new address phase
  assign w_canacc = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign w_accept = HSEL && HREADY && HTRANS[1] && w_canacc;
  assign w_fault  = w_accept && (!w_inrange || (HSIZE > 3'd2));
  assign w_accrd  = w_accept && !w_fault && !HWRITE;
  assign w_accwr  = w_accept && !w_fault && HWRITE;

  // The write data phase ends on the first edge with HREADY high
  assign w_we  = r_wpend && HREADY;
  assign w_fwd = w_we && (r_waddr == w_midx);

  assign w_ready   = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign HREADYOUT = w_ready;
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign HRDATA    = (r_rdpend && w_ready) ? r_ramq : r_hold;

  assign w_unused = ^{HPROT, HADDR[31:ADDR_WIDTH], HTRANS[0]};

  // Byte lanes of the address phase; misaligned low bits are simply masked
  always_comb begin
    w_lanes = 4'b0000;
    case (HSIZE[1:0])
      2'd0:    w_lanes = 4'b0001 << HADDR[1:0];
      2'd1:    w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_lanes = 4'b1111;
    endcase
  end

  // RAM read word, with lanes of a write completing at this same edge merged in
  always_comb begin
    w_rword = r_mem[w_midx];
    if (w_fwd) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wlanes[i]) w_rword[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Response FSM: wait-state countdown and two-cycle error sequence
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_ERR2: begin
          if (w_fault) begin
            r_state <= S_ERR1;
          end else if (w_accrd && (WS != 2'd0)) begin
            r_state <= S_WAIT;
            r_cnt   <= WS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd1) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_ERR1:  r_state <= S_ERR2;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture the word address and lanes of an accepted write for its data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wpend  <= 1'b0;
      r_waddr  <= '0;
      r_wlanes <= 4'b0000;
    end else if (HREADY) begin
      r_wpend <= w_accwr;
      if (w_accwr) begin
        r_waddr  <= w_midx;
        r_wlanes <= w_lanes;
      end
    end
  end

  // RAM array write port; contents are deliberately not reset
  always_ff @(posedge HCLK) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wlanes[i]) r_mem[r_waddr][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Read data register, plus the held copy shown once the read has completed
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ramq   <= 32'd0;
      r_rdpend <= 1'b0;
      r_hold   <= 32'd0;
    end else begin
      if (r_rdpend && w_ready) r_hold <= r_ramq;
      if (w_accrd) begin
        r_ramq   <= w_rword;
        r_rdpend <= 1'b1;
      end else if (w_ready) begin
        r_rdpend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram_ws.sv
// Self-checking bench for ahb_lite_sram_ws. Three slaves share one AHB-Lite
// bus, decoded on HADDR[15:14]: 0 = no wait states and 1000 words, 1 = two
// wait states, 2 = three wait states. HREADY, HRDATA and HRESP are muxed back
// from whichever slave owns the current data phase.
module tb_ahb_lite_sram_ws;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_NSEQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = TR_IDLE;
  logic [2:0]  HSIZE = 3'd2;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'd0;
  logic [3:0]  HPROT = 4'b0011;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  logic        sel0, sel2, sel3;
  logic        ready0, ready2, ready3;
  logic [31:0] rdata0, rdata2, rdata3;
  logic        resp0, resp2, resp3;
  logic [1:0]  dataSel;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] refMem [0:1][0:4095];

  always #5 HCLK = ~HCLK;

  assign sel0 = (HADDR[15:14] == 2'd0);
  assign sel2 = (HADDR[15:14] == 2'd1);
  assign sel3 = (HADDR[15:14] == 2'd2);

  ahb_lite_sram_ws #(.ADDR_WIDTH(14), .DEPTH_WORDS(1000), .READ_WS(0)) s0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(ready0), .HRDATA(rdata0), .HRESP(resp0));

  ahb_lite_sram_ws #(.ADDR_WIDTH(14), .DEPTH_WORDS(4096), .READ_WS(2)) s2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(ready2), .HRDATA(rdata2), .HRESP(resp2));

  ahb_lite_sram_ws #(.ADDR_WIDTH(14), .DEPTH_WORDS(4096), .READ_WS(3)) s3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel3), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(ready3), .HRDATA(rdata3), .HRESP(resp3));

  // Track which slave owns the data phase, like a bus matrix would
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dataSel <= 2'd3;
    else if (HREADY) dataSel <= HTRANS[1] ? HADDR[15:14] : 2'd3;
  end

  // Return-path mux driven by the data-phase owner
  always_comb begin
    case (dataSel)
      2'd0:    begin HREADY = ready0; HRDATA = rdata0; HRESP = resp0; end
      2'd1:    begin HREADY = ready2; HRDATA = rdata2; HRESP = resp2; end
      2'd2:    begin HREADY = ready3; HRDATA = rdata3; HRESP = resp3; end
      default: begin HREADY = 1'b1;   HRDATA = 32'd0;  HRESP = 1'b0;  end
    endcase
  end

  // Reference memory write: update each byte covered by the (aligned) transfer
  function automatic void modelWrite(input int sel, input logic [31:0] addr,
                                     input logic [2:0] size, input logic [31:0] data);
    int nBytes;
    int lane;
    logic [31:0] base;
    logic [31:0] word;
    nBytes = 1 << size;
    base = addr & ~(32'(nBytes) - 32'd1);
    word = refMem[sel][addr[13:2]];
    for (int b = 0; b < nBytes; b++) begin
      lane = int'((base + 32'(b)) & 32'd3);
      word[8*lane +: 8] = data[8*lane +: 8];
    end
    refMem[sel][addr[13:2]] = word;
  endfunction

  // One bus step, entered just after a rising edge: present an address phase
  // and the write data of the previous transfer, then run until HREADY ends
  // the current data phase. Reports wait cycles and the final response.
  task automatic step(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output int waits, output logic [31:0] rdata,
                      output logic respFirst, output logic respLast);
    bit done;
    bit first;
    HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr; HWDATA = wdata;
    waits = 0; rdata = 32'd0; respFirst = 1'b0; respLast = 1'b0;
    done = 0; first = 1;
    while (!done) begin
      @(negedge HCLK);
      if (first) respFirst = HRESP;
      first = 0;
      if (HREADY) begin
        rdata = HRDATA;
        respLast = HRESP;
        done = 1;
      end else begin
        waits++;
        if (waits > 20) begin
          compared++; mismatched++;
          $display("[TB] FAIL hready_timeout: got %0d wait cycles expected at most 20", waits);
          done = 1;
        end
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_reset();
    compared++;
    if ({ready0, ready2, ready3} !== 3'b111) begin
      mismatched++; $display("[TB] FAIL reset_hreadyout: got %b expected 111", {ready0, ready2, ready3});
    end
    compared++;
    if ({resp0, resp2, resp3} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL reset_hresp: got %b expected 000", {resp0, resp2, resp3});
    end
    compared++;
    if ((rdata0 | rdata2 | rdata3) !== 32'd0) begin
      mismatched++; $display("[TB] FAIL reset_hrdata: got %h/%h/%h expected 0", rdata0, rdata2, rdata3);
    end
  endtask

  task automatic test_word_rw();
    int w; logic [31:0] rd; logic rf, rl;
    step(TR_NSEQ, 1'b1, 3'd2, 32'h10, 32'h0, w, rd, rf, rl);
    step(TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF, w, rd, rf, rl);
    compared++;
    if (w !== 0 || rl !== 1'b0) begin
      mismatched++; $display("[TB] FAIL word_write_resp: got waits=%0d resp=%b expected 0/0", w, rl);
    end
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (rd !== 32'hDEADBEEF || w !== 0 || rl !== 1'b0) begin
      mismatched++; $display("[TB] FAIL word_read: got %h waits=%0d resp=%b expected deadbeef 0 0", rd, w, rl);
    end
  endtask

  task automatic test_byte_lanes();
    int w; logic [31:0] rd; logic rf, rl;
    step(TR_NSEQ, 1'b1, 3'd2, 32'h20, 32'h0, w, rd, rf, rl);
    step(TR_NSEQ, 1'b1, 3'd0, 32'h21, 32'h00000000, w, rd, rf, rl);
    step(TR_NSEQ, 1'b1, 3'd1, 32'h22, 32'h11111111, w, rd, rf, rl);
    step(TR_NSEQ, 1'b0, 3'd2, 32'h20, 32'hAABBAABB, w, rd, rf, rl);
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (rd !== 32'hAABB1100) begin
      mismatched++; $display("[TB] FAIL byte_lanes: got %h expected aabb1100", rd);
    end
  endtask

  task automatic test_forwarding();
    int w; logic [31:0] rd; logic rf, rl;
    step(TR_NSEQ, 1'b1, 3'd2, 32'h40, 32'h0, w, rd, rf, rl);
    step(TR_NSEQ, 1'b0, 3'd0, 32'h41, 32'h12345678, w, rd, rf, rl);
    step(TR_NSEQ, 1'b0, 3'd2, 32'h40, 32'h0, w, rd, rf, rl);
    compared++;
    if (rd !== 32'h12345678 || w !== 0) begin
      mismatched++; $display("[TB] FAIL forward_read: got %h waits=%0d expected 12345678 0", rd, w);
    end
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (rd !== 32'h12345678) begin
      mismatched++; $display("[TB] FAIL forward_followup: got %h expected 12345678", rd);
    end
  endtask

  task automatic test_wait_states();
    int w; logic [31:0] rd; logic rf, rl;
    step(TR_NSEQ, 1'b1, 3'd2, 32'h4000, 32'h0, w, rd, rf, rl);
    step(TR_NSEQ, 1'b0, 3'd2, 32'h4000, 32'hCAFEF00D, w, rd, rf, rl);
    step(TR_NSEQ, 1'b1, 3'd2, 32'h4004, 32'h0, w, rd, rf, rl);
    compared++;
    if (w !== 2 || rd !== 32'hCAFEF00D || rl !== 1'b0) begin
      mismatched++; $display("[TB] FAIL ws2_read: got %h waits=%0d resp=%b expected cafef00d 2 0", rd, w, rl);
    end
    step(TR_NSEQ, 1'b0, 3'd2, 32'h4004, 32'h600DF00D, w, rd, rf, rl);
    compared++;
    if (w !== 0) begin
      mismatched++; $display("[TB] FAIL ws2_held_write: got waits=%0d expected 0", w);
    end
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (w !== 2 || rd !== 32'h600DF00D) begin
      mismatched++; $display("[TB] FAIL ws2_held_readback: got %h waits=%0d expected 600df00d 2", rd, w);
    end
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (rdata2 !== 32'h600DF00D) begin
      mismatched++; $display("[TB] FAIL ws2_hrdata_hold: got %h expected 600df00d", rdata2);
    end
  endtask

  task automatic test_fault();
    int w; logic [31:0] rd; logic rf, rl;
    step(TR_NSEQ, 1'b1, 3'd2, 32'hF9C, 32'h0, w, rd, rf, rl);
    step(TR_NSEQ, 1'b1, 3'd2, 32'hFA0, 32'h99887766, w, rd, rf, rl);
    step(TR_NSEQ, 1'b0, 3'd2, 32'hF9C, 32'h00000055, w, rd, rf, rl);
    compared++;
    if (w !== 1 || rf !== 1'b1 || rl !== 1'b1) begin
      mismatched++; $display("[TB] FAIL range_error: got waits=%0d resp=%b,%b expected 1 1,1", w, rf, rl);
    end
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (rd !== 32'h99887766 || rl !== 1'b0 || w !== 0) begin
      mismatched++; $display("[TB] FAIL read_in_err2: got %h resp=%b waits=%0d expected 99887766 0 0", rd, rl, w);
    end
    step(TR_NSEQ, 1'b1, 3'd3, 32'h10, 32'h0, w, rd, rf, rl);
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'hFFFFFFFF, w, rd, rf, rl);
    compared++;
    if (w !== 1 || rf !== 1'b1 || rl !== 1'b1) begin
      mismatched++; $display("[TB] FAIL hsize_write_error: got waits=%0d resp=%b,%b expected 1 1,1", w, rf, rl);
    end
    step(TR_NSEQ, 1'b0, 3'd3, 32'h0, 32'h0, w, rd, rf, rl);
    step(TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0, w, rd, rf, rl);
    compared++;
    if (w !== 1 || rf !== 1'b1 || rl !== 1'b1) begin
      mismatched++; $display("[TB] FAIL hsize_read_error: got waits=%0d resp=%b,%b expected 1 1,1", w, rf, rl);
    end
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (rd !== 32'hDEADBEEF) begin
      mismatched++; $display("[TB] FAIL faulting_write_ignored: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_reset_midtransfer();
    int w; logic [31:0] rd; logic rf, rl;
    step(TR_NSEQ, 1'b1, 3'd2, 32'h8010, 32'h0, w, rd, rf, rl);
    step(TR_NSEQ, 1'b0, 3'd2, 32'h8010, 32'h01020304, w, rd, rf, rl);
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (w !== 3 || rd !== 32'h01020304) begin
      mismatched++; $display("[TB] FAIL ws3_read: got %h waits=%0d expected 01020304 3", rd, w);
    end
    step(TR_NSEQ, 1'b0, 3'd2, 32'h8010, 32'h0, w, rd, rf, rl);
    HTRANS = TR_IDLE;
    @(negedge HCLK);
    compared++;
    if (ready3 !== 1'b0) begin
      mismatched++; $display("[TB] FAIL ws3_in_wait: got hreadyout=%b expected 0", ready3);
    end
    #1 HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    compared++;
    if (ready3 !== 1'b1 || resp3 !== 1'b0 || rdata3 !== 32'd0) begin
      mismatched++; $display("[TB] FAIL reset_midwait: got ready=%b resp=%b data=%h expected 1 0 0", ready3, resp3, rdata3);
    end
    @(posedge HCLK); #1;
    step(TR_NSEQ, 1'b1, 3'd2, 32'h8010, 32'h0, w, rd, rf, rl);
    HTRANS = TR_IDLE; HWDATA = 32'hFFFFFFFF; HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    step(TR_NSEQ, 1'b0, 3'd2, 32'h8010, 32'h0, w, rd, rf, rl);
    step(TR_IDLE, 1'b0, 3'd2, 32'h0, 32'h0, w, rd, rf, rl);
    compared++;
    if (w !== 3 || rd !== 32'h01020304) begin
      mismatched++; $display("[TB] FAIL reset_discards_write: got %h waits=%0d expected 01020304 3", rd, w);
    end
  endtask

  task automatic test_back_to_back();
    int w; logic [31:0] rd; logic rf, rl;
    int total;
    logic [1:0] nTr; logic nWr; logic [2:0] nSize; logic [31:0] nAddr; logic [31:0] nData; int nSel;
    logic pValid; logic pWr; logic [2:0] pSize; logic [31:0] pAddr; logic [31:0] pData; int pSel;
    logic [31:0] expData; int expWaits;
    total = 16 + 120;
    pValid = 0; pWr = 0; pSize = 3'd2; pAddr = 32'd0; pData = 32'd0; pSel = 0;
    for (int i = 0; i <= total; i++) begin
      nTr = TR_NSEQ; nWr = 1'b1; nSize = 3'd2; nData = $urandom;
      if (i < 16) begin
        nSel = i / 8;
        nAddr = (32'(nSel) << 14) | (32'(32'h40 + (i % 8)) << 2);
      end else if (i == total || $urandom_range(0, 5) == 0) begin
        nTr = TR_IDLE; nSel = 0; nAddr = 32'd0;
      end else begin
        nSel = $urandom_range(0, 1);
        nWr = 1'(int'($urandom_range(0, 1)));
        nSize = 3'($urandom_range(0, 2));
        nAddr = (32'(nSel) << 14) | (32'(32'h40 + $urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      end
      step(nTr, nWr, nSize, nAddr, (pValid && pWr) ? pData : $urandom, w, rd, rf, rl);
      if (pValid) begin
        if (pWr) begin
          modelWrite(pSel, pAddr, pSize, pData);
          compared++;
          if (w !== 0 || rl !== 1'b0) begin
            mismatched++; $display("[TB] FAIL b2b_write @%h: got waits=%0d resp=%b expected 0 0", pAddr, w, rl);
          end
        end else begin
          expData = refMem[pSel][pAddr[13:2]];
          expWaits = (pSel == 1) ? 2 : 0;
          compared++;
          if (rd !== expData || w !== expWaits || rl !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_read @%h: got %h waits=%0d resp=%b expected %h %0d 0", pAddr, rd, w, rl, expData, expWaits);
          end
        end
      end
      pValid = nTr[1]; pWr = nWr; pSize = nSize; pAddr = nAddr; pData = nData; pSel = nSel;
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge HCLK);
    #1 test_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_forwarding();
    test_wait_states();
    test_fault();
    test_reset_midtransfer();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ahb_lite_sram_ws.md
Name: ahb_lite_sram_ws

Overview:
- AHB-Lite slave wrapping an inferred 32-bit synchronous single-port RAM.
- Generation-2 memory slave: parametrised depth (not necessarily a power of two) and parametrised read wait states for slow or deep-pipelined RAM macros.
- Adds read-after-write forwarding, plus a two-cycle ERROR response for out-of-range addresses and unsupported HSIZE.
- Sits on the AHB matrix as the main data/instruction RAM.

Parameters:
- ADDR_WIDTH, 14, byte-address bits decoded (HADDR[ADDR_WIDTH-1:0]); upper bits ignored (decoder owns HSEL).
- DEPTH_WORDS, 4096, number of 32-bit words implemented; must be <= 2^(ADDR_WIDTH-2).
- READ_WS, 0, read wait states inserted before read data is valid (0..3).

Ports:
- HCLK input 1 clock
- HRESETn input 1 reset; asynchronous, active-low
- HSEL input 1 slave select
- HADDR input 32 byte address
- HTRANS input 2 transfer type
- HSIZE input 3 transfer size
- HPROT input 4 protection (ignored)
- HWRITE input 1 1=write
- HWDATA input 32 write data (data phase)
- HREADY input 1 bus ready (previous transfer completing)
- HREADYOUT output 1 slave ready
- HRDATA output 32 read data
- HRESP output 1 0=OKAY, 1=ERROR

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, pending-write valid=0, all data-phase registers cleared. RAM contents are not reset.
- Accept: address phase is taken when HSEL&HREADY&HTRANS[1]. IDLE/BUSY or unselected gives zero-wait OKAY and no RAM access.
- Fault: accepted transfer with word index HADDR[ADDR_WIDTH-1:2] >= DEPTH_WORDS, or HSIZE>2.
  - Go to ERR1: HREADYOUT=0, HRESP=1. Then ERR2: HREADYOUT=1, HRESP=1. Then IDLE.
  - A faulting write never modifies RAM.
- Byte lanes: from HSIZE[1:0] and HADDR[1:0].
  - Byte: 1 lane at HADDR[1:0].
  - Halfword: lanes {1:0} or {3:2} by HADDR[1].
  - Word: all lanes.
  - Misaligned halfword/word is not checked; low address bits are masked.
- Write: data phase always zero-wait OKAY. Word address and lanes are registered at the address phase. RAM is written with HWDATA lanes on the edge ending the data phase (HREADY=1 while the write data phase is active).
- Read: RAM is read with HADDR word index at the address-phase edge.
  - READ_WS=0: HRDATA valid in the first data-phase cycle, HREADYOUT=1.
  - READ_WS=N: FSM enters WAIT with counter=N; HREADYOUT=0 for N cycles; HRDATA valid in the cycle HREADYOUT returns to 1.
  - HRDATA holds its value until the next read completes.
- Forwarding: a read address phase coinciding with a write data phase to the same word returns RAM data with the written lanes replaced by HWDATA lanes. Non-written lanes keep the old value.
- FSM: IDLE→WAIT (read, READ_WS>0); IDLE→ERR1 (fault); WAIT→IDLE when counter reaches 0; ERR1→ERR2→IDLE.
  - No new address phase can be accepted in WAIT or ERR1, because HREADY=0.
  - An accepted transfer in ERR2 is processed normally.
- Back-to-back: write→write, read→write and write→read all sustain one transfer per cycle at READ_WS=0.
- Reset mid-transfer: FSM→IDLE, pending write is discarded (RAM is not written), HREADYOUT=1 on the next cycle.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10 (READ_WS=0) → HRDATA=0xDEADBEEF in the first data cycle, HREADYOUT never 0, HRESP=0.
- Byte writes 0x11 @0x21 and halfword write 0xAABB @0x22 over a prior 0x00000000 → word read @0x20 returns 0xAABB1100.
- Write 0x12345678 @0x40 immediately followed by a byte read @0x41 in the write's data phase → HRDATA=0x12345678 via forwarding; the following read @0x40 also returns 0x12345678.
- READ_WS=2, read @0x0 containing 0xCAFEF00D → HREADYOUT=0 for exactly 2 cycles, then 1 with HRDATA=0xCAFEF00D. A pipelined next address is held until then.
- DEPTH_WORDS=1000, write 0x55 @ byte address 4000 (word 1000) → ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). A subsequent read @ word 999 is unaffected.
- HSIZE=3 read @0x0 → two-cycle ERROR. Assert HRESETn low during a READ_WS=3 wait → next cycle HREADYOUT=1, HRESP=0, FSM=IDLE.
